key_conditioner: RTL and testbench

- Front-end stage between the raw board push-buttons and the game control/datapath. Feeds the put, reset, right and down strobes.
- Per key: 2-flop synchroniser, debounce filter, one-cycle press strobe.
- Right and down keys also get hold-to-repeat strobes for cursor movement.
- Outputs are a debounced active-low key bus (drop-in for the raw buttons) plus single-cycle strobes.

---
 rtl/key_conditioner_if.sv | 25 ++
 rtl/key_conditioner.sv | 157 +++++++++++++++
 tb/tb_key_conditioner.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Key bus between the raw push-buttons and the conditioned control strobes.
// slave: the conditioner itself; master: the board / game side.
interface key_conditioner_if;
  logic [3:0] key_raw;
  logic [3:0] key_n;
  logic [3:0] held;
  logic [3:0] press_pulse;
  logic [1:0] step_pulse;

  modport master (
    output key_raw,
    input  key_n,
    input  held,
    input  press_pulse,
    input  step_pulse
  );

  modport slave (
    input  key_raw,
    output key_n,
    output held,
    output press_pulse,
    output step_pulse
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button front end: 2-flop sync, debounce, press strobes, hold-to-repeat on right/down.
// Define KEY_AUTO_REPEAT_EN to build the repeat FSMs; otherwise step_pulse = press_pulse[3:2].
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  key_conditioner_if.slave kif
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_RATE < 2 || REPEAT_DELAY < 1) begin : g_bad_repeat
    $error("key_conditioner: REPEAT_RATE must be >= 2 and REPEAT_DELAY >= 1");
  end

  logic [3:0]    s0_q, s1_q;
  logic [3:0]    st_q, st_d;
  logic [3:0]    press_q, press_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [1:0]    step_q, step_d;
  logic [1:0]    rep_fire;

  always_comb begin
    st_d    = st_q;
    press_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s1_q[i] == st_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        st_d[i]    = s1_q[i];
        // st differs from s1 here, so st=1 means this acceptance is a press
        press_d[i] = st_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_q    <= '1;
      s1_q    <= '1;
      st_q    <= '1;
      press_q <= '0;
      step_q  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s0_q    <= kif.key_raw;
      s1_q    <= s0_q;
      st_q    <= st_d;
      press_q <= press_d;
      step_q  <= step_d;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCW  = $clog2(RMAX);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RR_LAST = RCW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_REPEAT
  } rstate_e;

  rstate_e        rs_q [2];
  rstate_e        rs_d [2];
  logic [RCW-1:0] rc_q [2];
  logic [RCW-1:0] rc_d [2];

  // Release is seen through the registered stable level, so a strobe can
  // never land on the same edge as the press strobe of the same key.
  always_comb begin
    rep_fire = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      rs_d[k] = rs_q[k];
      rc_d[k] = rc_q[k];
      case (rs_q[k])
        R_IDLE: begin
          if (press_d[k+2]) begin
            rs_d[k] = R_DELAY;
            rc_d[k] = '0;
          end
        end
        R_DELAY: begin
          if (st_q[k+2]) begin
            rs_d[k] = R_IDLE;
            rc_d[k] = '0;
          end else if (rc_q[k] == RD_LAST) begin
            rep_fire[k] = 1'b1;
            rs_d[k]     = R_REPEAT;
            rc_d[k]     = '0;
          end else begin
            rc_d[k] = rc_q[k] + RCW'(1);
          end
        end
        R_REPEAT: begin
          if (st_q[k+2]) begin
            rs_d[k] = R_IDLE;
            rc_d[k] = '0;
          end else if (rc_q[k] == RR_LAST) begin
            rep_fire[k] = 1'b1;
            rc_d[k]     = '0;
          end else begin
            rc_d[k] = rc_q[k] + RCW'(1);
          end
        end
        default: begin
          rs_d[k] = R_IDLE;
          rc_d[k] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < 2; k++) begin
        rs_q[k] <= R_IDLE;
        rc_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        rs_q[k] <= rs_d[k];
        rc_q[k] <= rc_d[k];
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  assign step_d = press_d[3:2] | rep_fire;

  assign kif.key_n       = st_q;
  assign kif.held        = ~st_q;
  assign kif.press_pulse = press_q;
  assign kif.step_pulse  = step_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: window-based debounce model plus arithmetic repeat schedule,
// compared every cycle, with literal checks at hand-computed edges.
module tb_key_conditioner;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RR  = 3;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  key_conditioner_if kif ();

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kif  (kif)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // hist[j] = raw value sampled at the j-th edge since reset; the synchronised
  // level seen at edge n is hist[n-2]. A new level is accepted when the last
  // DEB synchronised samples all differ from the current stable level.
  logic [3:0] hist [$];
  logic [3:0] m_st    = 4'hF;
  logic [3:0] m_press = 4'h0;
  logic [1:0] m_step  = 2'b00;
  bit         m_act   [2];
  int         m_pedge [2];

  function automatic logic raw_bit(input int j, input int i);
    logic [3:0] v;
    if (j < 0) return 1'b1;
    v = hist[j];
    return v[i];
  endfunction

  int         mn;
  int         dd;
  bit         alld;
  logic [3:0] new_st;
  logic [1:0] rep_v;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hist.delete();
      m_st    = 4'hF;
      m_press = 4'h0;
      m_step  = 2'b00;
      for (int k = 0; k < 2; k++) begin
        m_act[k]   = 1'b0;
        m_pedge[k] = 0;
      end
    end else begin
      hist.push_back(kif.key_raw);
      mn      = hist.size() - 1;
      new_st  = m_st;
      m_press = 4'h0;
      for (int i = 0; i < 4; i++) begin
        alld = 1'b1;
        for (int j = mn - 2 - int'(DEB) + 1; j <= mn - 2; j++)
          if (raw_bit(j, i) == m_st[i]) alld = 1'b0;
        if (alld) begin
          new_st[i]  = ~m_st[i];
          m_press[i] = m_st[i];
        end
      end
      rep_v = 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (REP_EN && m_act[k]) begin
          if (m_st[k+2]) m_act[k] = 1'b0;
          else begin
            dd = mn - m_pedge[k];
            if (dd == int'(RD) || (dd > int'(RD) && (dd - int'(RD)) % int'(RR) == 0))
              rep_v[k] = 1'b1;
          end
        end
        if (REP_EN && m_press[k+2]) begin
          m_act[k]   = 1'b1;
          m_pedge[k] = mn;
        end
      end
      m_step = m_press[3:2] | rep_v;
      m_st   = new_st;
    end
  end

  always @(negedge clock) begin
    chk("key_n",       kif.key_n,       m_st);
    chk("held",        kif.held,        ~m_st);
    chk("press_pulse", kif.press_pulse, m_press);
    chk("step_pulse",  {2'b00, kif.step_pulse}, {2'b00, m_step});
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    kif.key_raw = 4'hF;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("rst_key_n", kif.key_n, 4'hF);
    chk("rst_held",  kif.held,  4'h0);
    chk("rst_press", kif.press_pulse, 4'h0);

    // clean press on put
    kif.key_raw = 4'b1110;
    tick(5);
    chk("cp_held_e4", kif.held, 4'h0);
    tick(1);
    chk("cp_press_e5", kif.press_pulse, 4'b0001);
    chk("cp_model_e5", m_press, 4'b0001);
    chk("cp_key_n_e5", kif.key_n, 4'b1110);
    chk("cp_held_e5",  kif.held,  4'b0001);
    chk("cp_step_e5",  {2'b00, kif.step_pulse}, 4'h0);
    tick(1);
    chk("cp_press_e6", kif.press_pulse, 4'h0);
    tick(6);
    chk("cp_press_held", kif.press_pulse, 4'h0);
    kif.key_raw = 4'hF;
    tick(12);
    chk("cp_released", kif.key_n, 4'hF);

    // glitch on right
    kif.key_raw = 4'b1011;
    tick(3);
    kif.key_raw = 4'hF;
    tick(10);
    chk("gl_key_n",  kif.key_n, 4'hF);
    chk("gl_press",  kif.press_pulse, 4'h0);

    // hold down for 30 cycles
    kif.key_raw = 4'b0111;
    tick(6);
    chk("rp_step_e5",  {2'b00, kif.step_pulse}, 4'b0010);
    chk("rp_press_e5", kif.press_pulse, 4'b1000);
    tick(9);
    chk("rp_step_e14", {2'b00, kif.step_pulse}, 4'b0000);
    tick(1);
    chk("rp_step_e15", {2'b00, kif.step_pulse}, {2'b00, REP_EN, 1'b0});
    tick(3);
    chk("rp_step_e18", {2'b00, kif.step_pulse}, {2'b00, REP_EN, 1'b0});
    tick(11);
    kif.key_raw = 4'hF;
    tick(12);
    chk("rp_step_idle", {2'b00, kif.step_pulse}, 4'h0);
    chk("rp_key_n",     kif.key_n, 4'hF);

    // simultaneous right + down
    kif.key_raw = 4'b0011;
    tick(6);
    chk("si_press_e5", kif.press_pulse, 4'b1100);
    chk("si_step_e5",  {2'b00, kif.step_pulse}, 4'b0011);
    tick(1);
    chk("si_press_e6", kif.press_pulse, 4'h0);
    kif.key_raw = 4'hF;
    tick(16);

    // reset in the middle of debouncing the reset key
    kif.key_raw = 4'b1101;
    tick(3);
    reset = 1'b1;
    #1;
    chk("mr_key_n", kif.key_n, 4'hF);
    chk("mr_held",  kif.held,  4'h0);
    chk("mr_press", kif.press_pulse, 4'h0);
    chk("mr_step",  {2'b00, kif.step_pulse}, 4'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("mr_press_e4", kif.press_pulse, 4'h0);
    tick(1);
    chk("mr_press_e5", kif.press_pulse, 4'b0010);
    chk("mr_key_n_e5", kif.key_n, 4'b1101);
    kif.key_raw = 4'hF;
    tick(12);
    chk("mr_released", kif.key_n, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
